// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register sequencer.
// Register map, CTRL/status bits and response codes of the mm I2C master.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_DEV,
    S_WR_REG,
    S_WR_DATA,
    S_WR_CTRL,
    S_WAIT,
    S_POLL,
    S_CHECK,
    S_RD_DATA,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [3:0] REG_DEV   = 4'h0;
  localparam logic [3:0] REG_REG   = 4'h1;
  localparam logic [3:0] REG_DATA  = 4'h2;
  localparam logic [3:0] REG_CTRL  = 4'h3;
  localparam logic [3:0] REG_RDATA = 4'h4;

  localparam int CTRL_START = 0;
  localparam int CTRL_WE    = 1;
  localparam int CTRL_DONE  = 5;
  localparam int CTRL_NACK  = 6;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_LEN     = 2'b11;

  // CTRL word that kicks off one I2C transaction.
  function automatic logic [31:0] ctrl_word(input logic we);
    logic [31:0] w;
    w = '0;
    w[CTRL_WE] = we;
    w[CTRL_START] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/i2c_seq_mm_port.sv
// Memory-mapped access port: one outstanding read or write.
// Strobe, address and data stay frozen from start until mm_ack.
module i2c_seq_mm_port
  import i2c_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [3:0]  mm_addr,
  output logic        mm_read,
  output logic        mm_write,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata,
  input  logic        mm_ack
);

  logic active;
  logic is_wr;
  logic unused_hi;

  // Launch an access when idle; retire it on acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      is_wr    <= 1'b0;
      mm_addr  <= '0;
      mm_wdata <= '0;
    end else if (active) begin
      if (mm_ack) active <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      is_wr    <= write;
      mm_addr  <= addr;
      mm_wdata <= wdata;
    end
  end

  // Acks seen while nothing is outstanding fall through here.
  assign done      = active & mm_ack;
  assign mm_read   = active & ~is_wr;
  assign mm_write  = active & is_wr;
  assign rdata     = mm_rdata[7:0];
  assign unused_hi = ^mm_rdata[31:8];

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Runs multi-byte I2C register reads/writes, one I2C
// transaction per byte, through an mm I2C master core.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter  int MAX_BYTES   = 4,
  parameter  int WAIT_CYCLES = 20000,
  parameter  int POLL_LIMIT  = 16,
  localparam int LW = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_we,
  input  logic [6:0]             cmd_dev,
  input  logic [7:0]             cmd_reg,
  input  logic [LW-1:0]          cmd_len,
  input  logic [8*MAX_BYTES-1:0] cmd_wdata,
  output logic                   rsp_done,
  output logic [1:0]             rsp_err,
  output logic [8*MAX_BYTES-1:0] rsp_rdata,
  output logic [LW-1:0]          rsp_count,
  output logic [3:0]             mm_addr,
  output logic                   mm_read,
  output logic                   mm_write,
  output logic [31:0]            mm_wdata,
  input  logic [31:0]            mm_rdata,
  input  logic                   mm_ack
);

  localparam int WW = $clog2(WAIT_CYCLES + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int DW = 8 * MAX_BYTES;

  state_t state, next;

  logic          c_we;
  logic [6:0]    c_dev;
  logic [7:0]    c_reg;
  logic [LW-1:0] c_len;
  logic [DW-1:0] c_wdata;
  logic [LW-1:0] idx;
  logic [PW-1:0] poll_cnt;
  logic [WW-1:0] wait_cnt;
  logic          st_done;
  logic          st_nack;

  logic          mm_start;
  logic          mm_wr;
  logic [3:0]    mm_a;
  logic [31:0]   mm_wd;
  logic          mm_done;
  logic [7:0]    mm_rd;

  logic          accept;
  logic          bad_len;
  logic          last;
  logic          poll_last;
  logic          wait_end;
  logic [7:0]    byte_reg;
  logic [7:0]    byte_wr;

  assign accept    = cmd_valid && (state == S_IDLE);
  assign bad_len   = (cmd_len == '0) || (cmd_len > LW'(MAX_BYTES));
  assign last      = (idx + LW'(1)) == c_len;
  assign poll_last = poll_cnt == PW'(POLL_LIMIT);
  assign wait_end  = wait_cnt == WW'(WAIT_CYCLES - 1);
  assign byte_reg  = c_reg + 8'(idx);
  assign byte_wr   = c_wdata[{idx, 3'b000} +: 8];

  i2c_seq_mm_port u_port (
    .clk      (clk),
    .reset    (reset),
    .start    (mm_start),
    .write    (mm_wr),
    .addr     (mm_a),
    .wdata    (mm_wd),
    .done     (mm_done),
    .rdata    (mm_rd),
    .mm_addr  (mm_addr),
    .mm_read  (mm_read),
    .mm_write (mm_write),
    .mm_wdata (mm_wdata),
    .mm_rdata (mm_rdata),
    .mm_ack   (mm_ack)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  // Next-state: access states advance on the port's done.
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:    if (cmd_valid) next = bad_len ? S_DONE : S_WR_DEV;
      S_WR_DEV:  if (mm_done) next = S_WR_REG;
      S_WR_REG:  if (mm_done) next = c_we ? S_WR_DATA : S_WR_CTRL;
      S_WR_DATA: if (mm_done) next = S_WR_CTRL;
      S_WR_CTRL: if (mm_done) next = S_POLL;
      S_POLL:    if (mm_done) next = S_CHECK;
      S_CHECK: begin
        if (st_nack)        next = S_DONE;
        else if (st_done)   next = c_we ? S_NEXT : S_RD_DATA;
        else if (poll_last) next = S_DONE;
        else                next = S_WAIT;
      end
      S_WAIT:    if (wait_end) next = S_POLL;
      S_RD_DATA: if (mm_done) next = S_NEXT;
      S_NEXT:    next = last ? S_DONE : S_WR_DEV;
      S_DONE:    next = S_IDLE;
      default:   next = S_IDLE;
    endcase
  end

  // Outputs: request to the mm port and handshake flags.
  always_comb begin
    mm_start  = 1'b0;
    mm_wr     = 1'b1;
    mm_a      = REG_DEV;
    mm_wd     = '0;
    cmd_ready = (state == S_IDLE);
    rsp_done  = (state == S_DONE);
    unique case (state)
      S_WR_DEV: begin
        mm_start = 1'b1;
        mm_a     = REG_DEV;
        mm_wd    = {25'd0, c_dev};
      end
      S_WR_REG: begin
        mm_start = 1'b1;
        mm_a     = REG_REG;
        mm_wd    = {24'd0, byte_reg};
      end
      S_WR_DATA: begin
        mm_start = 1'b1;
        mm_a     = REG_DATA;
        mm_wd    = {24'd0, byte_wr};
      end
      S_WR_CTRL: begin
        mm_start = 1'b1;
        mm_a     = REG_CTRL;
        mm_wd    = ctrl_word(c_we);
      end
      S_POLL: begin
        mm_start = 1'b1;
        mm_wr    = 1'b0;
        mm_a     = REG_CTRL;
      end
      S_RD_DATA: begin
        mm_start = 1'b1;
        mm_wr    = 1'b0;
        mm_a     = REG_RDATA;
      end
      default: ;
    endcase
  end

  // Command capture, byte/poll/wait counters and response fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_we      <= 1'b0;
      c_dev     <= '0;
      c_reg     <= '0;
      c_len     <= '0;
      c_wdata   <= '0;
      idx       <= '0;
      poll_cnt  <= '0;
      wait_cnt  <= '0;
      st_done   <= 1'b0;
      st_nack   <= 1'b0;
      rsp_err   <= ERR_OK;
      rsp_rdata <= '0;
      rsp_count <= '0;
    end else begin
      if (accept) begin
        c_we      <= cmd_we;
        c_dev     <= cmd_dev;
        c_reg     <= cmd_reg;
        c_len     <= cmd_len;
        c_wdata   <= cmd_wdata;
        idx       <= '0;
        rsp_err   <= bad_len ? ERR_LEN : ERR_OK;
        rsp_rdata <= '0;
        rsp_count <= '0;
      end
      if (state == S_WR_CTRL) poll_cnt <= '0;
      if (state == S_POLL && mm_done) begin
        poll_cnt <= poll_cnt + PW'(1);
        st_done  <= mm_rd[CTRL_DONE];
        st_nack  <= mm_rd[CTRL_NACK];
      end
      if (state == S_CHECK) begin
        wait_cnt <= '0;
        if (st_nack) rsp_err <= ERR_NACK;
        else if (!st_done && poll_last) rsp_err <= ERR_TIMEOUT;
      end
      if (state == S_WAIT) wait_cnt <= wait_cnt + WW'(1);
      if (state == S_RD_DATA && mm_done)
        rsp_rdata[{idx, 3'b000} +: 8] <= mm_rd;
      if (state == S_NEXT) begin
        idx       <= idx + LW'(1);
        rsp_count <= rsp_count + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: scripted mm I2C master slave
// with random ack latency, checked against a per-byte reference model.
module tb_i2c_reg_sequencer;

  localparam int MB = 4;
  localparam int WC = 8;
  localparam int PL = 4;
  localparam int LW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [6:0]    cmd_dev;
  logic [7:0]    cmd_reg;
  logic [LW-1:0] cmd_len;
  logic [31:0]   cmd_wdata;
  logic          rsp_done;
  logic [1:0]    rsp_err;
  logic [31:0]   rsp_rdata;
  logic [LW-1:0] rsp_count;
  logic [3:0]    mm_addr;
  logic          mm_read;
  logic          mm_write;
  logic [31:0]   mm_wdata;
  logic [31:0]   mm_rdata;
  logic          mm_ack;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(
    .MAX_BYTES  (MB),
    .WAIT_CYCLES(WC),
    .POLL_LIMIT (PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_dev   (cmd_dev),
    .cmd_reg   (cmd_reg),
    .cmd_len   (cmd_len),
    .cmd_wdata (cmd_wdata),
    .rsp_done  (rsp_done),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .rsp_count (rsp_count),
    .mm_addr   (mm_addr),
    .mm_read   (mm_read),
    .mm_write  (mm_write),
    .mm_wdata  (mm_wdata),
    .mm_rdata  (mm_rdata),
    .mm_ack    (mm_ack)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-byte status script: kind 0 = done from poll n,
  // 1 = nack from poll n, 2 = never finishes.
  int pk[MB];
  int pn[MB];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [36:0] log_q[$];
  logic [36:0] exp_q[$];
  logic [1:0]  exp_err;
  int          exp_cnt;
  logic [31:0] exp_rd;

  int          byte_no, poll_no, seed, max_delay, min_gap, viol;
  int          strobe_cyc, last_poll, dly = -1;
  logic        stray_en = 1'b0;
  logic        mon_off = 1'b0;
  logic        p_strobe = 1'b0;
  logic [37:0] p_sig;
  logic [6:0]  s_dev;
  logic [7:0]  s_reg;

  function automatic logic [7:0] rd_val(input logic [6:0] d,
                                        input logic [7:0] r,
                                        input int s);
    int v;
    v = int'(d) * 3 + int'(r) * 5 + s;
    return v[7:0];
  endfunction

  // Slave side of one access: log it and produce read data.
  task automatic serve();
    logic [31:0] junk;
    logic [7:0]  st;
    int          cur;
    junk = $urandom;
    if (mm_write) begin
      log_q.push_back({1'b1, mm_addr, mm_wdata});
      case (mm_addr)
        4'h0: s_dev = mm_wdata[6:0];
        4'h1: s_reg = mm_wdata[7:0];
        4'h3: begin poll_no = 0; byte_no++; end
        default: ;
      endcase
    end else begin
      log_q.push_back({1'b0, mm_addr, 32'h0});
      if (mm_addr == 4'h3) begin
        poll_no++;
        last_poll = cyc;
        cur = byte_no - 1;
        st = junk[7:0] & 8'h9F;
        if (cur >= 0 && cur < MB) begin
          if (pk[cur] == 1 && poll_no >= pn[cur]) st[6] = 1'b1;
          if (pk[cur] == 0 && poll_no >= pn[cur]) st[5] = 1'b1;
        end
        mm_rdata = {junk[31:8], st};
      end else if (mm_addr == 4'h4) begin
        mm_rdata = {junk[31:8], rd_val(s_dev, s_reg, seed)};
      end else begin
        mm_rdata = junk;
      end
    end
  endtask

  // mm slave with random ack delay plus handshake monitor.
  initial begin
    mm_ack = 1'b0;
    mm_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mon_off && !reset) begin
        if (mm_read && mm_write) viol++;
        if (p_strobe && !mm_ack &&
            p_sig != {mm_read, mm_write, mm_addr, mm_wdata}) viol++;
        p_strobe = mm_read | mm_write;
        p_sig = {mm_read, mm_write, mm_addr, mm_wdata};
        if (p_strobe) strobe_cyc++;
      end else begin
        p_strobe = 1'b0;
      end
      mm_ack = 1'b0;
      if (mon_off || reset) begin
        dly = -1;
      end else if (mm_read || mm_write) begin
        if (dly < 0) begin
          dly = int'($urandom_range(0, max_delay));
          if (mm_read && mm_addr == 4'h3 && poll_no > 0)
            if (cyc - last_poll < min_gap) min_gap = cyc - last_poll;
        end
        if (dly == 0) begin
          serve();
          mm_ack = 1'b1;
          dly = -1;
        end else begin
          dly--;
        end
      end else begin
        dly = -1;
        if (stray_en && $urandom_range(0, 5) == 0) mm_ack = 1'b1;
      end
    end
  end

  // Expected access list and response from the command and script.
  task automatic model(input logic we, input logic [6:0] dev,
                       input logic [7:0] rg, input int len,
                       input logic [31:0] wd);
    logic [7:0] r;
    logic [7:0] b;
    logic       ok, stop, nk, dn;
    exp_q.delete();
    exp_err = 2'b00;
    exp_cnt = 0;
    exp_rd = '0;
    if (len == 0 || len > MB) begin
      exp_err = 2'b11;
      return;
    end
    for (int i = 0; i < len; i++) begin
      r = rg + 8'(i);
      b = wd[i*8 +: 8];
      exp_q.push_back({1'b1, 4'h0, 25'd0, dev});
      exp_q.push_back({1'b1, 4'h1, 24'd0, r});
      if (we) exp_q.push_back({1'b1, 4'h2, 24'd0, b});
      exp_q.push_back({1'b1, 4'h3, 30'd0, we, 1'b1});
      ok = 1'b0;
      stop = 1'b0;
      for (int p = 1; p <= PL; p++) begin
        exp_q.push_back({1'b0, 4'h3, 32'h0});
        nk = (pk[i] == 1) && (p >= pn[i]);
        dn = (pk[i] == 0) && (p >= pn[i]);
        if (nk) begin stop = 1'b1; break; end
        if (dn) begin ok = 1'b1; break; end
      end
      if (stop) begin exp_err = 2'b01; break; end
      if (!ok) begin exp_err = 2'b10; break; end
      if (!we) begin
        exp_q.push_back({1'b0, 4'h4, 32'h0});
        exp_rd[i*8 +: 8] = rd_val(dev, r, seed);
      end
      exp_cnt++;
    end
  endtask

  task automatic prep(input logic we, input logic [6:0] dev,
                      input logic [7:0] rg, input int len,
                      input logic [31:0] wd, input int maxd);
    seed = int'($urandom_range(0, 255));
    model(we, dev, rg, len, wd);
    log_q.delete();
    byte_no = 0;
    poll_no = 0;
    max_delay = maxd;
    min_gap = 1000;
    viol = 0;
    strobe_cyc = 0;
  endtask

  task automatic launch(input string tag, input logic we,
                        input logic [6:0] dev, input logic [7:0] rg,
                        input int len, input logic [31:0] wd);
    int k;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, cmd_ready, 1'b1);
    @(negedge clk);
    cmd_we = we;
    cmd_dev = dev;
    cmd_reg = rg;
    cmd_len = LW'(len);
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom);
    cmd_dev = 7'($urandom);
    cmd_reg = 8'($urandom);
    cmd_len = LW'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic run_cmd(input string tag, input logic we,
                         input logic [6:0] dev, input logic [7:0] rg,
                         input int len, input logic [31:0] wd,
                         input int maxd);
    int n;
    prep(we, dev, rg, len, wd, maxd);
    launch(tag, we, dev, rg, len, wd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_busy"}, cmd_ready, 1'b0);
    end while (!rsp_done && n < 3000);
    check({tag, "_done"}, rsp_done, 1'b1);
    if (exp_err == 2'b11) begin
      check({tag, "_lat"}, 32'(n), 32'd1);
      check({tag, "_nostb"}, 32'(strobe_cyc), 32'd0);
    end
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_cnt"}, rsp_count, LW'(exp_cnt));
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_nacc"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_acc%0d", tag, i), log_q[i], exp_q[i]);
    check({tag, "_proto"}, 32'(viol), 32'd0);
    check({tag, "_gap"}, 32'(min_gap > WC), 32'd1);
    @(negedge clk);
    check({tag, "_pulse"}, {rsp_done, cmd_ready}, 2'b01);
    check({tag, "_hold"}, {rsp_err, rsp_count}, {exp_err, LW'(exp_cnt)});
  endtask

  task automatic set_plan(input int i, input int k, input int n);
    pk[i] = k;
    pn[i] = n;
  endtask

  initial begin
    int k, seen, len;
    logic we;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_dev = '0;
    cmd_reg = '0;
    cmd_len = '0;
    cmd_wdata = '0;
    for (int i = 0; i < MB; i++) set_plan(i, 0, 1);
    repeat (3) @(negedge clk);
    check("rst_flags", {cmd_ready, rsp_done, mm_read, mm_write}, 4'b1000);
    check("rst_rsp", {rsp_err, rsp_count, rsp_rdata}, '0);
    check("rst_mm", {mm_addr, mm_wdata}, '0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd("wr2", 1'b1, 7'h20, 8'h10, 2, 32'h0000_2211, 0);

    set_plan(0, 0, 2);
    set_plan(1, 0, 2);
    run_cmd("rdwrap", 1'b0, 7'h51, 8'hFF, 2, 32'h0, 0);

    set_plan(0, 0, 1);
    set_plan(1, 1, 1);
    set_plan(2, 0, 1);
    run_cmd("nack", 1'b0, 7'h12, 8'h30, 3, 32'h0, 3);

    set_plan(0, 2, 1);
    run_cmd("tmo", 1'b0, 7'h0A, 8'h44, 1, 32'h0, 2);

    run_cmd("len0", 1'b0, 7'h0B, 8'h01, 0, 32'h0, 0);
    run_cmd("len5", 1'b1, 7'h0C, 8'h02, 5, 32'hAABBCCDD, 0);

    set_plan(0, 0, 1);
    set_plan(1, 2, 1);
    prep(1'b0, 7'h33, 8'h40, 2, 32'h0, 1);
    launch("rstw", 1'b0, 7'h33, 8'h40, 2, 32'h0);
    k = 0;
    while ((byte_no < 2 || poll_no < 1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rstw_reach", 32'(k < 500), 32'd1);
    repeat (3) @(negedge clk);
    mon_off = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    check("rstw_flags", {cmd_ready, rsp_done, mm_read, mm_write}, 4'b1000);
    check("rstw_rsp", {rsp_err, rsp_count, rsp_rdata}, '0);
    check("rstw_mm", {mm_addr, mm_wdata}, '0);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_done || mm_read || mm_write) seen++;
    end
    check("rstw_quiet", 32'(seen), 32'd0);
    mon_off = 1'b0;
    set_plan(0, 0, 1);
    set_plan(1, 0, 3);
    run_cmd("after_rst", 1'b0, 7'h33, 8'h40, 2, 32'h0, 2);

    stray_en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < MB; i++) begin
        k = int'($urandom_range(0, 9));
        if (k < 7) set_plan(i, 0, int'($urandom_range(1, 5)));
        else if (k < 9) set_plan(i, 1, int'($urandom_range(1, 4)));
        else set_plan(i, 2, 1);
      end
      we = 1'($urandom);
      len = int'($urandom_range(0, 5));
      run_cmd($sformatf("rnd%0d", t), we, 7'($urandom),
              ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom),
              len, $urandom, 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_sequencer.md
I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_BYTES, default 4, the maximum bytes per command (1..16).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 20000, the idle clk cycles between status polls.
REQ-003 The block SHALL have parameter POLL_LIMIT, default 16, the maximum status polls per byte before timeout.
REQ-004 The block SHALL use reset reset, asynchronous, active-high; clock clk.
REQ-005 The block SHALL have these ports, listed as name, direction, width, meaning:
  clk  in  1  clock
  reset  in  1  async active-high reset
  cmd_valid  in  1  command request
  cmd_ready  out  1  high in IDLE only
  cmd_we  in  1  1=write, 0=read
  cmd_dev  in  7  I2C device address
  cmd_reg  in  8  first register address
  cmd_len  in  LW=$clog2(MAX_BYTES+1)  byte count
  cmd_wdata  in  8*MAX_BYTES  write bytes, byte i at [8i+7:8i]
  rsp_done  out  1  one-cycle completion pulse
  rsp_err  out  2  00 ok, 01 NACK, 10 timeout, 11 bad length
  rsp_rdata  out  8*MAX_BYTES  read bytes
  rsp_count  out  LW  bytes completed
  mm_addr  out  4  master register address
  mm_read  out  1  read strobe, held until mm_ack
  mm_write  out  1  write strobe, held until mm_ack
  mm_wdata  out  32  write data
  mm_rdata  in  32  read data, valid with mm_ack
  mm_ack  in  1  one-cycle access acknowledge

Function
REQ-006 A command SHALL be accepted when cmd_valid && cmd_ready; all cmd_* inputs are captured, and later changes are ignored.
REQ-007 cmd_len==0 or cmd_len>MAX_BYTES SHALL produce rsp_done with rsp_err=11 and rsp_count=0 on the next cycle, with no mm access.
REQ-008 Each byte i SHALL be one I2C transaction at register address (cmd_reg+i) mod 256; the address wraps 0xFF->0x00.
REQ-009 FSM states: IDLE, WR_DEV, WR_REG, WR_DATA (writes only), WR_CTRL, WAIT, POLL, CHECK, RD_DATA (reads only), NEXT, DONE.
REQ-010 The states SHALL issue these mm writes: WR_DEV writes {25'0,dev} to 0x0; WR_REG writes {24'0,reg} to 0x1; WR_DATA writes {24'0,byte i} to 0x2; WR_CTRL writes {30'0,we,1'b1} to 0x3.
REQ-011 POLL SHALL read 0x3; RD_DATA SHALL read 0x4; each state advances on mm_ack.
REQ-012 After WR_CTRL the FSM SHALL enter POLL directly; the first poll has no wait.
REQ-013 CHECK SHALL evaluate status in this priority: bit6 (NACK)=1 -> DONE with err 01; else bit5 (done)=1 -> RD_DATA (read) or NEXT (write); else, if the poll count equals POLL_LIMIT -> DONE with err 10; else -> WAIT.
REQ-014 WAIT SHALL count WAIT_CYCLES clk cycles, then go to POLL; the counter clears on entry.
REQ-015 RD_DATA SHALL store mm_rdata[7:0] into rsp_rdata byte i.
REQ-016 NEXT SHALL increment the byte index and rsp_count; it returns to WR_DEV if more bytes remain, else goes to DONE with err 00.
REQ-017 DONE SHALL pulse rsp_done for one cycle and return to IDLE; rsp_err, rsp_rdata and rsp_count hold until the next accept.
REQ-018 On error, rsp_count SHALL equal the bytes completed before the failing byte, and remaining bytes are not attempted.
REQ-019 mm_read and mm_write SHALL never be high together; at most one access is outstanding; mm_addr and mm_wdata are stable while a strobe is high.
REQ-020 mm_ack arriving with no strobe high SHALL be ignored.
REQ-021 At accept, rsp_rdata, rsp_err and rsp_count SHALL clear to 0.

Reset
REQ-022 Reset SHALL force the FSM to IDLE, cmd_ready=1, and all other outputs, counters and captured fields to 0, regardless of any in-flight mm access.
REQ-023 A reset asserted mid-command SHALL produce no rsp_done.

Structure
REQ-024 Package i2c_seq_pkg SHALL hold the state enum, the mm register addresses (0x0-0x4), the CTRL bit positions (start 0, we 1, done 5, nack 6) and the rsp_err codes.
REQ-025 One sub-module, i2c_seq_mm_port, SHALL hold mm strobe/ack handling and present a start/done interface to the FSM.

Verification (WAIT_CYCLES=8, POLL_LIMIT=4)
REQ-026 Write of dev 0x20, reg 0x10, len 2, data 0x11,0x22, with done on the first poll -> writes occur in order 0/1/2/3 per byte; rsp_err=00, rsp_count=2.
REQ-027 Read of reg 0xFF, len 2, with status done after 2 polls -> the second byte uses reg 0x00; a WAIT of 8 cycles separates the polls; rsp_rdata holds both bytes.
REQ-028 Status bit6 set on byte 1 of a 3-byte read -> rsp_err=01, rsp_count=1, no byte-2 accesses.
REQ-029 Status is never done -> exactly 4 polls are issued, then rsp_err=10, rsp_count=0.
REQ-030 cmd_len=0 -> rsp_err=11 next cycle with no mm strobes; reset during WAIT -> IDLE, no rsp_done, and the next command executes normally.
REQ-031 mm_ack delayed 0-5 cycles randomly -> results are identical and strobes are held until ack.
